intt_gs_butterfly: RTL and testbench

- Pipelined Gentleman-Sande butterfly for the inverse NTT datapath; the decimation-in-frequency counterpart of the forward Cooley-Tukey butterfly built on the modular adder.
- Per accepted operand set (a, b, w) it produces x = (a + b) mod Q and y = ((a - b) mod Q) * w mod Q.
- Sits between the INTT coefficient-memory read port and write-back port.
- Uses valid/ready handshakes on both sides and carries an opaque tag, the write-back address, alongside the data.

---
 rtl/intt_gs_butterfly_if.sv | 28 ++
 rtl/intt_gs_butterfly.sv | 97 +++++++++
 tb/tb_intt_gs_butterfly.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/intt_gs_butterfly_if.sv
// Operand/result handshake bundle for the INTT Gentleman-Sande butterfly.
// The master drives operands and out_ready; the slave is the butterfly itself.
interface intt_gs_butterfly_if #(
  parameter int WIDTH     = 32,
  parameter int TAG_WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic [WIDTH-1:0]     in_w;
  logic [TAG_WIDTH-1:0] in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_x;
  logic [WIDTH-1:0]     out_y;
  logic [TAG_WIDTH-1:0] out_tag;

  modport master (
    output in_valid, in_a, in_b, in_w, in_tag, out_ready,
    input  in_ready, out_valid, out_x, out_y, out_tag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_w, in_tag, out_ready,
    output in_ready, out_valid, out_x, out_y, out_tag
  );
endinterface

// File: rtl/intt_gs_butterfly.sv
// Pipelined GS butterfly: x = (a+b) mod Q, y = ((a-b) mod Q)*w mod Q.
// Four register ranks (S1, S2, S3, output) share one stall enable driven by the output side.
module intt_gs_butterfly #(
  parameter int          WIDTH     = 32,
  parameter int unsigned Q         = 8380417,
  parameter int          TAG_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  intt_gs_butterfly_if.slave    bus
);
  localparam int STAGES = 4;
  localparam int PW     = 2 * WIDTH;
  localparam int K      = $clog2(Q);
  localparam logic [WIDTH-1:0] QW = WIDTH'(Q);
  localparam logic [PW-1:0]    QP = PW'(Q);
  // Barrett constant floor(2^(2K)/Q), folded at elaboration
  localparam logic [PW-1:0]    MU = (PW'(1) << (2 * K)) / QP;

  logic [STAGES:1]      r_vld_pipe;
  logic [WIDTH-1:0]     r1_sum, r1_diff, r1_w;
  logic [TAG_WIDTH-1:0] r1_tag;
  logic [PW-1:0]        r2_p;
  logic [WIDTH-1:0]     r2_sum;
  logic [TAG_WIDTH-1:0] r2_tag;
  logic [PW-1:0]        r3_p, r3_q;
  logic [WIDTH-1:0]     r3_sum;
  logic [TAG_WIDTH-1:0] r3_tag;
  logic [WIDTH-1:0]     r_x, r_y;
  logic [TAG_WIDTH-1:0] r_tag;

  logic                 w_en;
  logic [WIDTH:0]       w_sum_raw, w_sum_red;
  logic [WIDTH-1:0]     w_diff;
  logic [PW-1:0]        w_t, w_tm, w_q;
  logic [PW-1:0]        w_r0, w_r1, w_r2;

  assign w_en         = !r_vld_pipe[STAGES] || bus.out_ready;
  assign bus.in_ready = w_en;

  // S1: modular add and subtract; the a<b branch adds Q-b so nothing goes negative
  assign w_sum_raw = {1'b0, bus.in_a} + {1'b0, bus.in_b};
  assign w_sum_red = (w_sum_raw >= {1'b0, QW}) ? w_sum_raw - {1'b0, QW} : w_sum_raw;
  assign w_diff    = (bus.in_a >= bus.in_b) ? bus.in_a - bus.in_b
                                            : bus.in_a + (QW - bus.in_b);

  // S3 quotient estimate; the true quotient exceeds it by at most 2
  assign w_t  = r2_p >> (K - 1);
  assign w_tm = w_t * MU;
  assign w_q  = w_tm >> (K + 1);

  // Output stage: remainder in [0, 3Q) brought into [0, Q)
  assign w_r0 = r3_p - r3_q * QP;
  assign w_r1 = (w_r0 >= QP) ? w_r0 - QP : w_r0;
  assign w_r2 = (w_r1 >= QP) ? w_r1 - QP : w_r1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      r1_sum     <= '0;
      r1_diff    <= '0;
      r1_w       <= '0;
      r1_tag     <= '0;
      r2_p       <= '0;
      r2_sum     <= '0;
      r2_tag     <= '0;
      r3_p       <= '0;
      r3_q       <= '0;
      r3_sum     <= '0;
      r3_tag     <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_tag      <= '0;
    end else if (w_en) begin
      r_vld_pipe <= {r_vld_pipe[STAGES-1:1], bus.in_valid};
      r1_sum     <= w_sum_red[WIDTH-1:0];
      r1_diff    <= w_diff;
      r1_w       <= bus.in_w;
      r1_tag     <= bus.in_tag;
      r2_p       <= {{WIDTH{1'b0}}, r1_diff} * {{WIDTH{1'b0}}, r1_w};
      r2_sum     <= r1_sum;
      r2_tag     <= r1_tag;
      r3_p       <= r2_p;
      r3_q       <= w_q;
      r3_sum     <= r2_sum;
      r3_tag     <= r2_tag;
      r_x        <= r3_sum;
      r_y        <= w_r2[WIDTH-1:0];
      r_tag      <= r3_tag;
    end
  end

  assign bus.out_valid = r_vld_pipe[STAGES];
  assign bus.out_x     = r_x;
  assign bus.out_y     = r_y;
  assign bus.out_tag   = r_tag;
endmodule

// File: tb/tb_intt_gs_butterfly.sv
// Scoreboard bench for intt_gs_butterfly: driver pushes expected results,
// a negedge monitor pops and compares whenever a result completes.
module tb_intt_gs_butterfly;
  localparam int W  = 32;
  localparam int TW = 8;
  localparam longint unsigned Q = 64'd8380417;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  intt_gs_butterfly_if #(.WIDTH(W), .TAG_WIDTH(TW)) bus ();

  intt_gs_butterfly #(.WIDTH(W), .Q(8380417), .TAG_WIDTH(TW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0]  x;
    logic [W-1:0]  y;
    logic [TW-1:0] tag;
    longint        t_acc;
    bit            chk_lat;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, req, $time);
    end
  endtask

  // Monitor
  exp_t          m_e;
  bit            prev_stall = 0;
  logic [W-1:0]  px, py;
  logic [TW-1:0] ptag;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("in_ready_rule", longint'(bus.in_ready), longint'(!bus.out_valid || bus.out_ready));
      if (prev_stall) begin
        chk("stall_valid_held", longint'(bus.out_valid), 1);
        chk("stall_x_held",     longint'(bus.out_x),   longint'(px));
        chk("stall_y_held",     longint'(bus.out_y),   longint'(py));
        chk("stall_tag_held",   longint'(bus.out_tag), longint'(ptag));
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      px = bus.out_x; py = bus.out_y; ptag = bus.out_tag;
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_out actual_tag=%0d required=none x=%0d y=%0d",
                   bus.out_tag, bus.out_x, bus.out_y);
        end else begin
          m_e = sb.pop_front();
          chk("out_tag", longint'(bus.out_tag), longint'(m_e.tag));
          chk("out_x",   longint'(bus.out_x),   longint'(m_e.x));
          chk("out_y",   longint'(bus.out_y),   longint'(m_e.y));
          if (m_e.chk_lat) chk("latency_time", $time - m_e.t_acc, 35);
        end
      end
    end else begin
      prev_stall = 0;
    end
  end

  // Present one set, hold until accepted (bounded), push its expected result.
  longint t_first     = -1;
  bit     mark_first  = 0;
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] w,
                      input logic [TW-1:0] tag, input logic [W-1:0] x, input logic [W-1:0] y,
                      input bit lat);
    bit acc, done;
    exp_t e;
    done = 0;
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_w = w; bus.in_tag = tag;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      if (acc) begin
        e.x = x; e.y = y; e.tag = tag; e.t_acc = $time; e.chk_lat = lat;
        sb.push_back(e);
        if (mark_first && t_first < 0) t_first = $time;
        done = 1;
      end
      #1;
    end
    bus.in_valid = 1'b0;
    if (!done) begin
      checks++; failures++;
      $display("FAIL accept_timeout actual=not_accepted required=accepted tag=%0d", tag);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic gold(input longint unsigned a, input longint unsigned b, input longint unsigned w,
                      output logic [W-1:0] x, output logic [W-1:0] y);
    x = W'((a + b) % Q);
    y = W'((((a + Q - b) % Q) * w) % Q);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  logic [W-1:0] ra[20], rb[20], rw[20], gx, gy;

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_w = '0; bus.in_tag = '0;
    bus.out_ready = 1'b1;
    #1;
    chk("rst_out_valid", longint'(bus.out_valid), 0);
    chk("rst_out_x",     longint'(bus.out_x), 0);
    chk("rst_out_y",     longint'(bus.out_y), 0);
    chk("rst_out_tag",   longint'(bus.out_tag), 0);
    chk("rst_in_ready",  longint'(bus.in_ready), 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // Directed vectors, latency checked
    send(32'd5,       32'd3,       32'd1,       8'h11, 32'd8,       32'd2,       1);
    idle(4);
    send(32'd3,       32'd5,       32'd1,       8'h12, 32'd8,       32'd8380415, 1);
    send(32'd10,      32'd4,       32'd8380416, 8'h13, 32'd14,      32'd8380411, 1);
    send(32'd8380416, 32'd8380416, 32'd7,       8'h14, 32'd8380415, 32'd0,       1);
    send(32'd8380416, 32'd0,       32'd8380416, 8'h15, 32'd8380416, 32'd1,       1);
    idle(5);

    // Bubbles: valid pattern 1,0,1,0,1
    send(32'd100,     32'd200,     32'd3,       8'h21, 32'd300,     32'd8380117, 1);
    idle(1);
    send(32'd7,       32'd7,       32'd9,       8'h22, 32'd14,      32'd0,       1);
    idle(1);
    send(32'd8380000, 32'd417,     32'd0,       8'h23, 32'd0,       32'd0,       1);
    idle(6);

    // Streaming with a 5-cycle output stall
    for (int i = 0; i < 20; i++) begin
      ra[i] = W'($urandom_range(0, 8380416));
      rb[i] = W'($urandom_range(0, 8380416));
      rw[i] = W'($urandom_range(0, 8380416));
    end
    mark_first = 1;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          gold(longint'(ra[i]), longint'(rb[i]), longint'(rw[i]), gx, gy);
          send(ra[i], rb[i], rw[i], TW'(i), gx, gy, 0);
        end
      end
      begin
        int c;
        bit started;
        c = 0; started = 0;
        for (int k = 0; k < 300 && c <= 10; k++) begin
          @(posedge clk);
          #1;
          if (started) c++;
          else if (t_first >= 0) begin started = 1; c = 0; end
          bus.out_ready = !(started && c >= 6 && c <= 10);
        end
        bus.out_ready = 1'b1;
      end
    join
    mark_first = 0;
    for (int k = 0; k < 100 && sb.size() != 0; k++) @(posedge clk);
    #1;
    chk("stream_drained", longint'(sb.size()), 0);

    // Reset mid-operation with a result parked at the output
    bus.out_ready = 1'b0;
    send(32'd11, 32'd22, 32'd33, 8'h31, 32'd0, 32'd0, 0);
    send(32'd44, 32'd55, 32'd66, 8'h32, 32'd0, 32'd0, 0);
    send(32'd77, 32'd88, 32'd99, 8'h33, 32'd0, 32'd0, 0);
    idle(2);
    chk("pre_rst_valid", longint'(bus.out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", longint'(bus.out_valid), 0);
    chk("midrst_out_x",     longint'(bus.out_x), 0);
    chk("midrst_out_y",     longint'(bus.out_y), 0);
    chk("midrst_out_tag",   longint'(bus.out_tag), 0);
    chk("midrst_in_ready",  longint'(bus.in_ready), 1);
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    idle(6);
    send(32'd1, 32'd1, 32'd2, 8'h5A, 32'd2, 32'd0, 1);
    for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
    idle(2);
    chk("final_drained", longint'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
